serial_tx_scheduler: RTL

Round-robin scheduler that shares one `parallel_to_serial` serializer among `n_req` word producers. It accepts one word at a time into a holding register through per-requester valid/ready handshakes. It issues each word to the serializer as soon as the line is free, so accepted words leave with no gap between them. It sits directly upstream of the serializer and reports which requester owns the bit currently on the serial line.

---
 rtl/serial_tx_sched_pkg.sv | 20 ++
 rtl/serial_tx_scheduler_rr_arbiter.sv | 33 +++
 rtl/serial_tx_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_tx_sched_pkg.sv
// Shared width helpers and index type for the serial TX scheduler.
// Optional feature macro used by the top level: SERIAL_TX_SCHED_GAP_EN.
package serial_tx_sched_pkg;

    // Requester index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Shift counter width, wide enough to hold the word width itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEF_N_REQ = 4;
    localparam int DEF_IDX_W = idx_width(DEF_N_REQ);

    typedef logic [DEF_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request after 'last', with wrap.
module rr_arbiter
    import serial_tx_sched_pkg::*;
#(
    parameter int n_req = 4
) (
    input  logic [n_req-1:0]            req,
    input  logic [idx_width(n_req)-1:0] last,
    output logic [n_req-1:0]            grant,
    output logic [idx_width(n_req)-1:0] grant_idx,
    output logic                        any
);

    localparam int IW = idx_width(n_req);

    always_comb begin
        logic [IW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        // k = n_req revisits 'last' itself, so it is searched at lowest priority.
        for (int k = 1; k <= n_req; k++) begin
            idx = IW'((int'(last) + k) % n_req);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin word scheduler feeding a shared parallel-to-serial serializer.
// Define SERIAL_TX_SCHED_GAP_EN to insert one idle line cycle between words.
module serial_tx_scheduler
    import serial_tx_sched_pkg::*;
#(
    parameter int width = 8,
    parameter int n_req = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [n_req-1:0]         req_valid,
    input  logic [n_req*width-1:0]   req_data,
    output logic [n_req-1:0]         req_ready,
    output logic                     ser_parallel_valid,
    output logic [width-1:0]         ser_parallel_data,
    input  logic                     ser_busy,
    output logic [$clog2(n_req)-1:0] ser_src,
    output logic                     ser_active,
    output logic                     idle,
    output logic                     protocol_err
);

    localparam int IW = idx_width(n_req);
    localparam int CW = cnt_width(width);
`ifdef SERIAL_TX_SCHED_GAP_EN
    localparam logic [CW-1:0] CNT_LOAD = CW'(width);
`else
    localparam logic [CW-1:0] CNT_LOAD = CW'(width - 1);
`endif

    logic [width-1:0] words [n_req];

    for (genvar gi = 0; gi < n_req; gi++) begin : g_words
        assign words[gi] = req_data[gi*width +: width];
    end

    logic             hold_valid_q, hold_valid_d;
    logic [width-1:0] hold_data_q,  hold_data_d;
    logic [IW-1:0]    hold_src_q,   hold_src_d;
    logic [IW-1:0]    cur_src_q,    cur_src_d;
    logic [IW-1:0]    last_q,       last_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic             err_q,        err_d;

    logic [n_req-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             any;
    logic             accept;
    logic             issue;

    rr_arbiter #(.n_req(n_req)) u_arb (
        .req       (req_valid),
        .last      (last_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_comb begin
        accept       = !hold_valid_q && any && !rst;
        issue        = hold_valid_q && (cnt_q == '0);
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_src_d   = hold_src_q;
        cur_src_d    = cur_src_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        err_d        = err_q | (issue & ser_busy);

        // Accept and issue are mutually exclusive: they need opposite hold_valid.
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = words[grant_idx];
            hold_src_d   = grant_idx;
            last_d       = grant_idx;
        end
        if (issue) begin
            hold_valid_d = 1'b0;
            cnt_d        = CNT_LOAD;
            cur_src_d    = hold_src_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_src_q   <= '0;
            cur_src_q    <= '0;
            last_q       <= IW'(n_req - 1);
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_src_q   <= hold_src_d;
            cur_src_q    <= cur_src_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign req_ready          = accept ? grant : '0;
    assign ser_parallel_valid = issue;
    assign ser_parallel_data  = hold_data_q;
    assign ser_src            = issue ? hold_src_q : cur_src_q;
`ifdef SERIAL_TX_SCHED_GAP_EN
    // cnt==1 is the gap cycle: the line is quiet but the scheduler is not idle.
    assign ser_active         = issue || (cnt_q > CW'(1));
`else
    assign ser_active         = issue || (cnt_q != '0);
`endif
    assign idle               = !hold_valid_q && (cnt_q == '0);
    assign protocol_err       = err_q;

endmodule
